// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute FSM that decodes the datapath IR and drives every datapath strobe.
// Optional macro CTRL_STEP_EN adds a step input; T-states then advance (and strobe) only when step=1.
module control_sequencer #(
  parameter int OPW      = 5,
  parameter int RSW      = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           clr,
`ifdef CTRL_STEP_EN
  input  logic           step,
`endif
  input  logic           run_req,
  input  logic [31:0]    ir,
  input  logic           mem_rdy,
  output logic           PCout,
  output logic           MARin,
  output logic           IncPC,
  output logic           PCin,
  output logic           Read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           ZLowOut,
  output logic           ZHighOut,
  output logic           HIin,
  output logic           LOin,
  output logic           Rin,
  output logic           Rout,
  output logic [RSW-1:0] rsel,
  output logic [OPW-1:0] alu_op,
  output logic           running,
  output logic           halted,
  output logic           fault
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, FAULT
  } state_t;

  state_t         state;
  logic [CW-1:0]  wait_cnt;
  logic           adv;

`ifdef CTRL_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  logic [OPW-1:0] op;
  logic [RSW-1:0] ra, rb, rc;
  logic           unused_ir;

  assign op = ir[31 -: OPW];
  assign ra = ir[31-OPW -: RSW];
  assign rb = ir[31-OPW-RSW -: RSW];
  assign rc = ir[31-OPW-2*RSW -: RSW];
  assign unused_ir = ^ir[31-OPW-3*RSW:0];

  logic is_bin, is_mul, is_un, is_nop, is_halt;

  always_comb begin
    is_bin  = 1'b0;
    is_mul  = 1'b0;
    is_un   = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR: is_bin  = 1'b1;
      OP_MUL, OP_DIV:                is_mul  = 1'b1;
      OP_NEG, OP_NOT:                is_un   = 1'b1;
      OP_NOP:                        is_nop  = 1'b1;
      OP_HALT:                       is_halt = 1'b1;
      default: ;
    endcase
  end

  // Wait counter tolerates WAIT_MAX stalled cycles; the next stalled cycle faults.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (run_req) state <= T0;
        T0:   if (adv) state <= T1;
        T1: if (adv) begin
          if (mem_rdy) begin
            state    <= T2;
            wait_cnt <= '0;
          end else if (wait_cnt == CW'(WAIT_MAX)) begin
            state    <= FAULT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        T2: if (adv) state <= T3;
        T3: if (adv) begin
          if (is_bin || is_mul) state <= T4;
          else if (is_un)       state <= T5;
          else if (is_nop)      state <= run_req ? T0 : IDLE;
          else if (is_halt)     state <= HALT;
          else                  state <= FAULT;
        end
        T4: if (adv) state <= T5;
        T5: if (adv) begin
          if (is_mul) state <= T6;
          else        state <= run_req ? T0 : IDLE;
        end
        T6:      if (adv) state <= run_req ? T0 : IDLE;
        HALT:    state <= HALT;
        FAULT:   state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

  // Strobes decode from state so T1's ready-cycle pulses track mem_rdy in the same cycle.
  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    rsel     = '0;
    alu_op   = '0;
    running  = (state inside {T0, T1, T2, T3, T4, T5, T6});
    halted   = (state == HALT);
    fault    = (state == FAULT);
    if (adv) begin
      case (state)
        T0: begin
          PCout  = 1'b1;
          MARin  = 1'b1;
          IncPC  = 1'b1;
          Zin    = 1'b1;
          alu_op = OP_ADD;
        end
        T1: begin
          Read = 1'b1;
          if (mem_rdy) begin
            MDRin   = 1'b1;
            ZLowOut = 1'b1;
            PCin    = 1'b1;
          end
        end
        T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        T3: begin
          if (is_bin || is_mul) begin
            Rout = 1'b1;
            rsel = rb;
            Yin  = 1'b1;
          end else if (is_un) begin
            Rout   = 1'b1;
            rsel   = rb;
            Zin    = 1'b1;
            alu_op = op;
          end
        end
        T4: begin
          Rout   = 1'b1;
          rsel   = rc;
          Zin    = 1'b1;
          alu_op = op;
        end
        T5: begin
          ZLowOut = 1'b1;
          if (is_mul) begin
            LOin = 1'b1;
          end else begin
            Rin  = 1'b1;
            rsel = ra;
          end
        end
        T6: begin
          ZHighOut = 1'b1;
          HIin     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small behavioural datapath executes the strobes while a
// scoreboard of expected per-cycle output vectors is compared against the DUT each cycle.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        run_req;
  logic [31:0] ir;
  logic        mem_rdy;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin;
  logic        ZLowOut, ZHighOut, HIin, LOin, Rin, Rout;
  logic [3:0]  rsel;
  logic [4:0]  alu_op;
  logic        running, halted, fault;
`ifdef CTRL_STEP_EN
  logic        step = 1'b1;
`endif

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr),
`ifdef CTRL_STEP_EN
    .step(step),
`endif
    .run_req(run_req), .ir(ir), .mem_rdy(mem_rdy),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
    .Rin(Rin), .Rout(Rout), .rsel(rsel), .alu_op(alu_op),
    .running(running), .halted(halted), .fault(fault)
  );

  // Strobe mask bits, MSB first in the observed vector.
  localparam logic [15:0] S_PCOUT = 16'h8000, S_MARIN = 16'h4000, S_INCPC = 16'h2000,
                          S_PCIN  = 16'h1000, S_READ  = 16'h0800, S_MDRIN = 16'h0400,
                          S_MDROUT= 16'h0200, S_IRIN  = 16'h0100, S_YIN   = 16'h0080,
                          S_ZIN   = 16'h0040, S_ZLO   = 16'h0020, S_ZHI   = 16'h0010,
                          S_HIIN  = 16'h0008, S_LOIN  = 16'h0004, S_RIN   = 16'h0002,
                          S_ROUT  = 16'h0001;
  localparam logic [2:0] F_RUN = 3'b100, F_HLT = 3'b010, F_FLT = 3'b001, F_NONE = 3'b000;

  logic [27:0] ovec;
  assign ovec = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin,
                 ZLowOut, ZHighOut, HIin, LOin, Rin, Rout, rsel, alu_op,
                 running, halted, fault};

  // Behavioural datapath and memory.
  logic [31:0] mem   [16];
  logic [31:0] rinit [16];
  logic [31:0] regs  [16];
  logic [31:0] pc, mar, mdr, irr, y, hi, lo, bus;
  logic [63:0] z;
  int          stall;
  int          rd_wait;

  assign ir      = irr;
  assign mem_rdy = Read && (rd_wait >= stall);

  always_comb begin
    bus = 32'h0;
    if (PCout)         bus = pc;
    else if (MDRout)   bus = mdr;
    else if (Rout)     bus = regs[rsel];
    else if (ZLowOut)  bus = z[31:0];
    else if (ZHighOut) bus = z[63:32];
  end

  function automatic logic [63:0] alu(input logic [4:0] a, input logic [31:0] ya,
                                      input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{ya[31]}}, ya}) * $signed({{32{b[31]}}, b});
    case (a)
      5'b00011: return {32'h0, ya + b};
      5'b00100: return {32'h0, ya - b};
      5'b01001: return {32'h0, ya & b};
      5'b01010: return {32'h0, ya | b};
      5'b01110: return p;
      5'b10000: return {32'h0, 32'h0 - b};
      5'b10001: return {32'h0, ~b};
      default:  return 64'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!clr) begin
      pc <= 0; mar <= 0; mdr <= 0; irr <= 0; y <= 0; z <= 0; hi <= 0; lo <= 0;
      rd_wait <= 0;
      for (int i = 0; i < 16; i++) regs[i] <= rinit[i];
    end else begin
      rd_wait <= (Read && !mem_rdy) ? rd_wait + 1 : 0;
      if (MARin) mar <= bus;
      if (PCin)  pc  <= bus;
      if (MDRin) mdr <= mem[mar[3:0]];
      if (IRin)  irr <= bus;
      if (Yin)   y   <= bus;
      if (Zin)   z   <= IncPC ? {32'h0, bus + 32'd1} : alu(alu_op, y, bus);
      if (Rin)   regs[rsel] <= bus;
      if (LOin)  lo  <= bus;
      if (HIin)  hi  <= bus;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [27:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic logic [27:0] mk(input logic [15:0] s, input logic [3:0] r,
                                     input logic [4:0] a, input logic [2:0] f);
    return {s, r, a, f};
  endfunction

  task automatic push_fetch(input int waits);
    exp_q.push_back(mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 4'd0, 5'b00011, F_RUN));
    repeat (waits) exp_q.push_back(mk(S_READ, 4'd0, 5'd0, F_RUN));
    exp_q.push_back(mk(S_READ | S_MDRIN | S_ZLO | S_PCIN, 4'd0, 5'd0, F_RUN));
    exp_q.push_back(mk(S_MDROUT | S_IRIN, 4'd0, 5'd0, F_RUN));
  endtask

  // Expected execute-phase vectors for one instruction word.
  task automatic push_exec(input logic [31:0] ins);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = ins[31:27]; ra = ins[26:23]; rb = ins[22:19]; rc = ins[18:15];
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
        exp_q.push_back(mk(S_ROUT | S_YIN, rb, 5'd0, F_RUN));
        exp_q.push_back(mk(S_ROUT | S_ZIN, rc, op, F_RUN));
        exp_q.push_back(mk(S_ZLO | S_RIN, ra, 5'd0, F_RUN));
      end
      5'd14, 5'd15: begin
        exp_q.push_back(mk(S_ROUT | S_YIN, rb, 5'd0, F_RUN));
        exp_q.push_back(mk(S_ROUT | S_ZIN, rc, op, F_RUN));
        exp_q.push_back(mk(S_ZLO | S_LOIN, 4'd0, 5'd0, F_RUN));
        exp_q.push_back(mk(S_ZHI | S_HIIN, 4'd0, 5'd0, F_RUN));
      end
      5'd16, 5'd17: begin
        exp_q.push_back(mk(S_ROUT | S_ZIN, rb, op, F_RUN));
        exp_q.push_back(mk(S_ZLO | S_RIN, ra, 5'd0, F_RUN));
      end
      default: exp_q.push_back(mk(16'h0, 4'd0, 5'd0, F_RUN));
    endcase
  endtask

  task automatic push_n(input int n, input logic [2:0] f);
    repeat (n) exp_q.push_back(mk(16'h0, 4'd0, 5'd0, f));
  endtask

  // Pops one expected vector per DUT cycle; cycle 0 is the first T0.
  task automatic run_seq(input string name, input int drop_at);
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      if (k == drop_at) run_req = 1'b0;
      @(negedge clk);
      check($sformatf("%s_cyc%0d", name, k), {4'h0, ovec}, {4'h0, exp_q.pop_front()});
      k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    run_req = 1'b0;
    #1;
    check("reset_outputs_zero", {4'h0, ovec}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
  endtask

  localparam logic [31:0] I_AND  = 32'h4A920000;  // AND R5,R2,R4
  localparam logic [31:0] I_MUL  = 32'h703C0000;  // MUL rb=R7, rc=R8
  localparam logic [31:0] I_NEG  = 32'h83400000;  // NEG R6,R8
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_ADD  = 32'h18920000;  // ADD R1,R2,R4
  localparam logic [31:0] I_BAD  = 32'hF8000000;

  initial begin
    clr = 1'b0;
    run_req = 1'b0;
    stall = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0;
      rinit[i] = 32'h0;
    end
    rinit[2] = 32'h22; rinit[4] = 32'h24; rinit[7] = 32'd16; rinit[8] = 32'hFFFFFFFE;

    // Program: AND, MUL, NEG, NOP, HALT with zero memory wait.
    mem[0] = I_AND; mem[1] = I_MUL; mem[2] = I_NEG; mem[3] = I_NOP; mem[4] = I_HALT;
    do_reset();
    @(negedge clk);
    check("idle_no_run", {4'h0, ovec}, 32'h0);
    run_req = 1'b1;
    push_fetch(0); push_exec(I_AND);
    push_fetch(0); push_exec(I_MUL);
    push_fetch(0); push_exec(I_NEG);
    push_fetch(0); push_exec(I_NOP);
    push_fetch(0); push_exec(I_HALT);
    push_n(3, F_HLT);
    run_seq("prog", -1);
    check("and_r5", regs[5], 32'h20);
    check("mul_lo", lo, 32'hFFFFFFE0);
    check("mul_hi", hi, 32'hFFFFFFFF);
    check("neg_r6", regs[6], 32'h2);
    check("pc_after_halt", pc, 32'd5);

    // Three wait cycles; run_req dropped in T3 so the ADD completes then idles.
    mem[0] = I_ADD;
    stall = 3;
    do_reset();
    run_req = 1'b1;
    push_fetch(3); push_exec(I_ADD); push_n(3, F_NONE);
    run_seq("wait3_drop", 6);
    check("add_r1", regs[1], 32'h46);

    // Exactly WAIT_MAX stalls is still tolerated.
    mem[0] = I_NOP;
    stall = 15;
    do_reset();
    run_req = 1'b1;
    push_fetch(15); push_exec(I_NOP); push_n(2, F_NONE);
    run_seq("wait15", 18);

    // One more stall cycle faults.
    stall = 16;
    do_reset();
    run_req = 1'b1;
    exp_q.push_back(mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 4'd0, 5'b00011, F_RUN));
    repeat (16) exp_q.push_back(mk(S_READ, 4'd0, 5'd0, F_RUN));
    push_n(3, F_FLT);
    run_seq("timeout", -1);

    // Illegal opcode faults at T3.
    mem[0] = I_BAD;
    stall = 0;
    do_reset();
    run_req = 1'b1;
    push_fetch(0); push_exec(I_BAD); push_n(3, F_FLT);
    run_seq("illegal", -1);

    // Asynchronous reset during T4, then restart.
    mem[0] = I_AND;
    do_reset();
    run_req = 1'b1;
    push_fetch(0);
    exp_q.push_back(mk(S_ROUT | S_YIN, 4'd2, 5'd0, F_RUN));
    exp_q.push_back(mk(S_ROUT | S_ZIN, 4'd4, 5'b01001, F_RUN));
    run_seq("pre_clr", -1);
    #2;
    clr = 1'b0;
    #1;
    check("clr_async_in_t4", {4'h0, ovec}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    exp_q.push_back(mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 4'd0, 5'b00011, F_RUN));
    run_seq("restart", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
